// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 5/2/1 coin change dispenser with pulse/gap sequencing and tube inventory
module change_dispenser #(
    parameter int PULSE_CYCLES = 100000,
    parameter int GAP_CYCLES   = 200000,
    parameter int TUBE_INIT    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  change_amount,
    input  logic        refill,
    output logic        eject_coin1,
    output logic        eject_coin2,
    output logic        eject_coin5,
    output logic        busy,
    output logic        done,
    output logic        short_change,
    output logic [7:0]  remaining,
    output logic [11:0] tube_levels
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    TUBE_FULL  = 4'(TUBE_INIT);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN1, COIN2, COIN5} coin_t;

    state_t        state;
    state_t        state_next;
    coin_t         sel;
    coin_t         pick;
    logic [CW-1:0] cnt;
    logic [3:0]    cnt1;
    logic [3:0]    cnt2;
    logic [3:0]    cnt5;
    logic          pulse_last;
    logic          gap_last;

    assign tube_levels = {cnt5, cnt2, cnt1};

    // Greedy choice: largest coin that fits the remaining amount and whose tube is not empty
    always_comb begin
        pick = COIN_NONE;
        if (remaining >= 8'd5 && cnt5 != 4'd0) begin
            pick = COIN5;
        end else if (remaining >= 8'd2 && cnt2 != 4'd0) begin
            pick = COIN2;
        end else if (remaining >= 8'd1 && cnt1 != 4'd0) begin
            pick = COIN1;
        end
    end

    // Next-state logic and state-decoded outputs; ejects are derived from the registered state
    // so a reset drops them on the same edge that aborts the sequence
    always_comb begin
        state_next  = state;
        eject_coin1 = 1'b0;
        eject_coin2 = 1'b0;
        eject_coin5 = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        pulse_last  = (cnt == PULSE_LAST);
        gap_last    = (cnt == GAP_LAST);
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (change_amount == 8'd0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                state_next = (pick == COIN_NONE) ? S_DONE : S_EJECT;
            end
            S_EJECT: begin
                eject_coin1 = (sel == COIN1);
                eject_coin2 = (sel == COIN2);
                eject_coin5 = (sel == COIN5);
                if (pulse_last) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_next = (remaining == 8'd0) ? S_DONE : S_SELECT;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shared pulse/gap timer, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst || state_next != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Request bookkeeping: amount still owed, chosen coin, shortfall flag and tube counts
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= 8'd0;
            short_change <= 1'b0;
            sel          <= COIN_NONE;
            cnt1         <= TUBE_FULL;
            cnt2         <= TUBE_FULL;
            cnt5         <= TUBE_FULL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (refill) begin
                        cnt1 <= TUBE_FULL;
                        cnt2 <= TUBE_FULL;
                        cnt5 <= TUBE_FULL;
                    end
                    if (start) begin
                        remaining    <= change_amount;
                        short_change <= 1'b0;
                    end
                end
                S_SELECT: begin
                    sel <= pick;
                    if (pick == COIN_NONE) begin
                        short_change <= 1'b1;
                    end
                end
                S_EJECT: begin
                    if (pulse_last) begin
                        case (sel)
                            COIN5: begin
                                remaining <= remaining - 8'd5;
                                cnt5      <= cnt5 - 4'd1;
                            end
                            COIN2: begin
                                remaining <= remaining - 8'd2;
                                cnt2      <= cnt2 - 4'd1;
                            end
                            COIN1: begin
                                remaining <= remaining - 8'd1;
                                cnt1      <= cnt1 - 4'd1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_r = 1'b0;
    logic        refill_r = 1'b0;
    logic [7:0]  change_amount = 8'd0;
    logic        which = 1'b0;

    logic        a_e1, a_e2, a_e5, a_busy, a_done, a_short;
    logic [7:0]  a_rem;
    logic [11:0] a_tubes;
    logic        b_e1, b_e2, b_e5, b_busy, b_done, b_short;
    logic [7:0]  b_rem;
    logic [11:0] b_tubes;

    logic        start_a, start_b, refill_a, refill_b;
    logic [2:0]  m_e;
    logic        m_busy, m_done, m_short;
    logic [7:0]  m_rem;
    logic [11:0] m_tubes;

    int checks = 0;
    int errors = 0;

    int         obs_n;
    logic [2:0] obs_coin [8];
    int         obs_width [8];
    int         done_cyc;
    int         busy_cnt;
    int         req_amt = 0;
    int         ej_sum = 0;
    logic [2:0] prev_e = 3'b000;

    assign start_a  = start_r && !which;
    assign start_b  = start_r && which;
    assign refill_a = refill_r && !which;
    assign refill_b = refill_r && which;
    assign m_e      = which ? {b_e5, b_e2, b_e1} : {a_e5, a_e2, a_e1};
    assign m_busy   = which ? b_busy : a_busy;
    assign m_done   = which ? b_done : a_done;
    assign m_short  = which ? b_short : a_short;
    assign m_rem    = which ? b_rem : a_rem;
    assign m_tubes  = which ? b_tubes : a_tubes;

    change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2), .TUBE_INIT(10)) dut (
        .clk(clk), .rst(rst), .start(start_a), .change_amount(change_amount), .refill(refill_a),
        .eject_coin1(a_e1), .eject_coin2(a_e2), .eject_coin5(a_e5), .busy(a_busy), .done(a_done),
        .short_change(a_short), .remaining(a_rem), .tube_levels(a_tubes)
    );

    change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2), .TUBE_INIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_b), .change_amount(change_amount), .refill(refill_b),
        .eject_coin1(b_e1), .eject_coin2(b_e2), .eject_coin5(b_e5), .busy(b_busy), .done(b_done),
        .short_change(b_short), .remaining(b_rem), .tube_levels(b_tubes)
    );

    always #5 clk = ~clk;

    function automatic int coin_val(input logic [2:0] e);
        case (e)
            3'b100:  return 5;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    // Invariant monitor on the selected instance: one-hot ejects, done inside busy, value conservation
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((m_e & (m_e - 3'd1)) != 3'd0) begin
                errors++;
                $display("FAIL onehot_ejects actual=%b required=onehot0", m_e);
            end
            checks++;
            if (m_done && !m_busy) begin
                errors++;
                $display("FAIL done_without_busy actual done=1 busy=0 required busy=1");
            end
            if (prev_e != 3'd0 && m_e != prev_e) ej_sum += coin_val(prev_e);
            if (!m_busy) begin
                ej_sum = 0;
            end else begin
                checks++;
                if (ej_sum + int'(m_rem) != req_amt) begin
                    errors++;
                    $display("FAIL conservation actual=%0d required=%0d", ej_sum + int'(m_rem), req_amt);
                end
            end
            prev_e = m_e;
        end
    end

    // Issue one request and record eject pulses, busy cycles and the done cycle (edge 0 = start sampled)
    task automatic run_req(input logic [7:0] amt, input int limit, input int poke);
        obs_n    = 0;
        done_cyc = -1;
        busy_cnt = 0;
        @(posedge clk); #1;
        req_amt       = int'(amt);
        change_amount = amt;
        start_r       = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            if (m_busy) busy_cnt++;
            if (m_e != 3'd0) begin
                if (obs_n > 0 && obs_coin[obs_n-1] == m_e && k > 1 && obs_width[obs_n-1] > 0 && prev_e == m_e) begin
                    obs_width[obs_n-1]++;
                end else if (obs_n < 8) begin
                    obs_coin[obs_n]  = m_e;
                    obs_width[obs_n] = 1;
                    obs_n++;
                end
            end
            if (m_done) begin
                done_cyc = k;
                break;
            end
            if (k == poke) begin
                start_r       = 1'b1;
                refill_r      = 1'b1;
                change_amount = 8'd9;
            end else if (k == poke + 1) begin
                start_r  = 1'b0;
                refill_r = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_r  = 1'b0;
        refill_r = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_e5, a_e2, a_e1, a_busy, a_done, a_short} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=000000", {a_e5, a_e2, a_e1, a_busy, a_done, a_short});
        end
        checks++;
        if (a_rem !== 8'd0) begin
            errors++;
            $display("FAIL reset_remaining actual=%0d required=0", a_rem);
        end
        checks++;
        if (a_tubes !== 12'hAAA) begin
            errors++;
            $display("FAIL reset_tubes actual=%h required=aaa", a_tubes);
        end
        checks++;
        if (b_tubes !== 12'h111) begin
            errors++;
            $display("FAIL reset_tubes_init1 actual=%h required=111", b_tubes);
        end
        rst = 1'b0;
    endtask

    task automatic test_greedy_8;
        which = 1'b0;
        run_req(8'd8, 40, -10);
        checks++;
        if (done_cyc !== 19) begin
            errors++;
            $display("FAIL g8_done_cycle actual=%0d required=19", done_cyc);
        end
        checks++;
        if (obs_n !== 3) begin
            errors++;
            $display("FAIL g8_pulse_count actual=%0d required=3", obs_n);
        end else begin
            checks++;
            if ({obs_coin[0], obs_coin[1], obs_coin[2]} !== 9'b100_010_001) begin
                errors++;
                $display("FAIL g8_order actual=%b %b %b required=100 010 001", obs_coin[0], obs_coin[1], obs_coin[2]);
            end
            checks++;
            if (obs_width[0] != 3 || obs_width[1] != 3 || obs_width[2] != 3) begin
                errors++;
                $display("FAIL g8_widths actual=%0d %0d %0d required=3 3 3", obs_width[0], obs_width[1], obs_width[2]);
            end
        end
        checks++;
        if (m_rem !== 8'd0 || m_short !== 1'b0) begin
            errors++;
            $display("FAIL g8_rem_short actual=%0d/%b required=0/0", m_rem, m_short);
        end
        checks++;
        if (m_tubes !== 12'h999) begin
            errors++;
            $display("FAIL g8_tubes actual=%h required=999", m_tubes);
        end
        @(posedge clk); #1;
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL g8_idle_after actual busy=%b done=%b required=0 0", m_busy, m_done);
        end
    endtask

    task automatic test_zero;
        which = 1'b0;
        run_req(8'd0, 10, -10);
        checks++;
        if (done_cyc !== 1) begin
            errors++;
            $display("FAIL zero_done_cycle actual=%0d required=1", done_cyc);
        end
        checks++;
        if (obs_n !== 0 || busy_cnt !== 1) begin
            errors++;
            $display("FAIL zero_pulses_busy actual=%0d/%0d required=0/1", obs_n, busy_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (m_busy !== 1'b0 || m_rem !== 8'd0) begin
            errors++;
            $display("FAIL zero_after actual busy=%b rem=%0d required=0 0", m_busy, m_rem);
        end
    endtask

    task automatic test_short;
        which = 1'b1;
        run_req(8'd8, 40, -10);
        checks++;
        if (done_cyc !== 19 || m_tubes !== 12'h000 || m_short !== 1'b0) begin
            errors++;
            $display("FAIL short_first actual=%0d/%h/%b required=19/000/0", done_cyc, m_tubes, m_short);
        end
        run_req(8'd7, 40, -10);
        checks++;
        if (done_cyc !== 2) begin
            errors++;
            $display("FAIL short_done_cycle actual=%0d required=2", done_cyc);
        end
        checks++;
        if (obs_n !== 0) begin
            errors++;
            $display("FAIL short_pulses actual=%0d required=0", obs_n);
        end
        checks++;
        if (m_short !== 1'b1 || m_rem !== 8'd7 || m_tubes !== 12'h000) begin
            errors++;
            $display("FAIL short_result actual=%b/%0d/%h required=1/7/000", m_short, m_rem, m_tubes);
        end
        @(posedge clk); #1;
        checks++;
        if (m_rem !== 8'd7 || m_short !== 1'b1) begin
            errors++;
            $display("FAIL short_hold actual=%0d/%b required=7/1", m_rem, m_short);
        end
        which = 1'b0;
    endtask

    task automatic test_ignore_busy;
        which = 1'b0;
        @(posedge clk); #1;
        refill_r = 1'b1;
        @(posedge clk); #1;
        refill_r = 1'b0;
        checks++;
        if (m_tubes !== 12'hAAA) begin
            errors++;
            $display("FAIL refill_idle actual=%h required=aaa", m_tubes);
        end
        run_req(8'd4, 40, 3);
        checks++;
        if (done_cyc !== 13 || obs_n !== 2) begin
            errors++;
            $display("FAIL ign_done_pulses actual=%0d/%0d required=13/2", done_cyc, obs_n);
        end else begin
            checks++;
            if (obs_coin[0] !== 3'b010 || obs_coin[1] !== 3'b010) begin
                errors++;
                $display("FAIL ign_coins actual=%b %b required=010 010", obs_coin[0], obs_coin[1]);
            end
        end
        checks++;
        if (m_rem !== 8'd0 || m_tubes !== 12'hA8A) begin
            errors++;
            $display("FAIL ign_result actual=%0d/%h required=0/a8a", m_rem, m_tubes);
        end
        @(posedge clk); #1;
        refill_r = 1'b1;
        @(posedge clk); #1;
        refill_r = 1'b0;
        checks++;
        if (m_tubes !== 12'hAAA) begin
            errors++;
            $display("FAIL ign_refill_after actual=%h required=aaa", m_tubes);
        end
    endtask

    task automatic test_mid_reset;
        which = 1'b0;
        run_req(8'd5, 40, -10);
        checks++;
        if (done_cyc !== 7 || m_tubes !== 12'h9AA) begin
            errors++;
            $display("FAIL mr_first actual=%0d/%h required=7/9aa", done_cyc, m_tubes);
        end
        @(posedge clk); #1;
        req_amt       = 8;
        change_amount = 8'd8;
        start_r       = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_e5 !== 1'b1) begin
            errors++;
            $display("FAIL mr_in_eject actual=%b required=1", a_e5);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_e5 !== 1'b0 || a_busy !== 1'b0 || a_rem !== 8'd0 || a_tubes !== 12'hAAA) begin
            errors++;
            $display("FAIL mr_abort actual=%b/%b/%0d/%h required=0/0/0/aaa", a_e5, a_busy, a_rem, a_tubes);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_greedy_8;
        test_zero;
        test_short;
        test_ignore_busy;
        test_mid_reset;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
